// File: rtl/snk_ioctl_loader_if.sv
// Download/ROM-write bus between hps_io and the loader, and from the loader
// into the ROM regions. The master side is the host/ROM side and the slave
// side is the loader.
interface snk_ioctl_loader_if #(
  parameter int NREG = 4
);
  logic            ioctl_download;
  logic [7:0]      ioctl_index;
  logic            ioctl_wr;
  logic [24:0]     ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;
  logic [NREG-1:0] rgn_rdy;
  logic [NREG-1:0] rgn_wr;
  logic [24:0]     rgn_addr;
  logic [7:0]      rgn_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rgn_rdy,
    input  ioctl_wait, rgn_wr, rgn_addr, rgn_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rgn_rdy,
    output ioctl_wait, rgn_wr, rgn_addr, rgn_data
  );
endinterface

// File: rtl/snk_ioctl_loader.sv
// ioctl download sequencer for the TripleZ80 core.
//
// Index-0 bytes are routed to one of NREG ROM regions. The region is the
// highest one whose base is <= the address, and the write port gets the
// offset into that region. A region that is not ready stalls hps_io through
// ioctl_wait, with a one-byte holding register. Index 1 sets the game select
// byte and index 254 sets the DIP banks. core_rstn is held low until a
// download has finished and a further RST_HOLD cycles have passed.
module snk_ioctl_loader #(
  parameter int                 NREG        = 4,
  parameter logic [NREG*25-1:0] REGION_BASE = {25'h30000, 25'h20000, 25'h10000, 25'h0},
  parameter logic [24:0]        ROM_END     = 25'h40000,
  parameter int                 RST_HOLD    = 16
) (
  input  logic                     i_clk,
  input  logic                     RESETn,
  snk_ioctl_loader_if.slave        bus,
  output logic [7:0]               game,
  output logic [7:0]               dsw1,
  output logic [7:0]               dsw2,
  output logic                     rom_loaded,
  output logic                     rom_overflow,
  output logic                     core_rstn
);

  localparam int SELW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CNTW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  typedef enum logic [2:0] {IDLE, ROM, HOLD, POST, RUN} state_t;

  state_t            state_q, state_d;
  logic              wait_q, wait_d;
  logic [NREG-1:0]   wr_q, wr_d;
  logic [24:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [SELW-1:0]   pend_rgn_q, pend_rgn_d;
  logic [24:0]       pend_off_q, pend_off_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              loaded_q, loaded_d;
  logic              ovf_q, ovf_d;
  logic              crst_q, crst_d;
  logic [7:0]        game_q, dsw1_q, dsw2_q;

  // Region decode: ascending bases, so the last match is the highest region.
  // Regions that start at or past ROM_END can never own a byte.
  logic              hit;
  logic [SELW-1:0]   sel;
  logic [24:0]       sel_base;
  logic [24:0]       sel_off;

  // Address decode for the incoming byte
  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    sel_base = '0;
    for (int i = 0; i < NREG; i++) begin
      if ((REGION_BASE[i*25 +: 25] < ROM_END) &&
          (bus.ioctl_addr >= REGION_BASE[i*25 +: 25])) begin
        hit      = 1'b1;
        sel      = SELW'(i);
        sel_base = REGION_BASE[i*25 +: 25];
      end
    end
    sel_off = bus.ioctl_addr - sel_base;
  end

  logic start_rom;
  logic rom_byte;
  assign start_rom = bus.ioctl_download && (bus.ioctl_index == 8'd0);
  assign rom_byte  = bus.ioctl_wr && (bus.ioctl_index == 8'd0);

  // Download FSM: next state, write strobes, stall and load status
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    wr_d        = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_rgn_d  = pend_rgn_q;
    pend_off_d  = pend_off_q;
    pend_data_d = pend_data_q;
    cnt_d       = cnt_q;
    loaded_d    = loaded_q;
    ovf_d       = ovf_q;
    crst_d      = crst_q;
    case (state_q)
      IDLE, RUN: begin
        if (start_rom) begin
          state_d  = ROM;
          loaded_d = 1'b0;
          ovf_d    = 1'b0;
          crst_d   = 1'b0;
        end
      end
      ROM: begin
        if (!bus.ioctl_download) begin
          state_d = POST;
          cnt_d   = CNTW'(RST_HOLD);
        end else if (rom_byte) begin
          if (bus.ioctl_addr >= ROM_END) begin
            ovf_d = 1'b1;
          end else if (hit) begin
            if (bus.rgn_rdy[sel]) begin
              wr_d[sel] = 1'b1;
              addr_d    = sel_off;
              data_d    = bus.ioctl_dout;
            end else begin
              // Park the byte and stall hps_io until the region frees up
              pend_rgn_d  = sel;
              pend_off_d  = sel_off;
              pend_data_d = bus.ioctl_dout;
              wait_d      = 1'b1;
              state_d     = HOLD;
            end
          end
        end
      end
      HOLD: begin
        // Any ioctl_wr seen here breaks the wait protocol and is dropped. If the
        // download ended meanwhile, ROM moves on to POST after this write.
        if (bus.rgn_rdy[pend_rgn_q]) begin
          wr_d[pend_rgn_q] = 1'b1;
          addr_d           = pend_off_q;
          data_d           = pend_data_q;
          wait_d           = 1'b0;
          state_d          = ROM;
        end
      end
      POST: begin
        if (cnt_q <= CNTW'(1)) begin
          state_d  = RUN;
          cnt_d    = '0;
          loaded_d = 1'b1;
          crst_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset drops any parked byte
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      wait_q      <= 1'b0;
      wr_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_rgn_q  <= '0;
      pend_off_q  <= '0;
      pend_data_q <= '0;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      ovf_q       <= 1'b0;
      crst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_rgn_q  <= pend_rgn_d;
      pend_off_q  <= pend_off_d;
      pend_data_q <= pend_data_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      ovf_q       <= ovf_d;
      crst_q      <= crst_d;
    end
  end

  // Game select and DIP capture; accepted in any FSM state and never stalls
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      game_q <= '0;
      dsw1_q <= '0;
      dsw2_q <= '0;
    end else if (bus.ioctl_wr) begin
      if ((bus.ioctl_index == 8'd1) && (bus.ioctl_addr == 25'd0))
        game_q <= bus.ioctl_dout;
      if ((bus.ioctl_index == 8'd254) && (bus.ioctl_addr < 25'd2)) begin
        if (bus.ioctl_addr[0]) dsw2_q <= bus.ioctl_dout;
        else                   dsw1_q <= bus.ioctl_dout;
      end
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.rgn_wr     = wr_q;
  assign bus.rgn_addr   = addr_q;
  assign bus.rgn_data   = data_q;
  assign game           = game_q;
  assign dsw1           = dsw1_q;
  assign dsw2           = dsw2_q;
  assign rom_loaded     = loaded_q;
  assign rom_overflow   = ovf_q;
  assign core_rstn      = crst_q;

endmodule

// File: tb/tb_snk_ioctl_loader.sv
// Directed bench for snk_ioctl_loader. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_snk_ioctl_loader;

  logic i_clk = 1'b0;
  logic RESETn = 1'b0;
  logic [7:0] game, dsw1, dsw2;
  logic rom_loaded, rom_overflow, core_rstn;

  int n_cmp = 0;
  int n_err = 0;

  snk_ioctl_loader_if #(.NREG(4)) bus ();

  snk_ioctl_loader dut (
    .i_clk        (i_clk),
    .RESETn       (RESETn),
    .bus          (bus),
    .game         (game),
    .dsw1         (dsw1),
    .dsw2         (dsw2),
    .rom_loaded   (rom_loaded),
    .rom_overflow (rom_overflow),
    .core_rstn    (core_rstn)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [3:0]  exp_wr;
    logic [24:0] exp_off;
  } rom_vec_t;

  rom_vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Present one byte for a single cycle; on return rgn_* shows its result
  task automatic put_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    cyc();
    bus.ioctl_wr    = 1'b0;
  endtask

  // End the download, then check that core_rstn and rom_loaded rise on the 16th edge
  task automatic finish_load(input string tag);
    bus.ioctl_download = 1'b0;
    repeat (16) cyc();
    chk({tag, " core_rstn still low at 15"}, 32'(core_rstn), 32'd0);
    chk({tag, " rom_loaded still low at 15"}, 32'(rom_loaded), 32'd0);
    cyc();
    chk({tag, " core_rstn rises"}, 32'(core_rstn), 32'd1);
    chk({tag, " rom_loaded rises"}, 32'(rom_loaded), 32'd1);
  endtask

  initial begin
    vecs[0] = '{25'h00000, 8'hA1, 4'b0001, 25'h0};
    vecs[1] = '{25'h00005, 8'hB2, 4'b0001, 25'h5};
    vecs[2] = '{25'h0FFFF, 8'hC3, 4'b0001, 25'hFFFF};
    vecs[3] = '{25'h10000, 8'hD4, 4'b0010, 25'h0};
    vecs[4] = '{25'h10005, 8'hE5, 4'b0010, 25'h5};
    vecs[5] = '{25'h1FFFF, 8'h16, 4'b0010, 25'hFFFF};
    vecs[6] = '{25'h20000, 8'h27, 4'b0100, 25'h0};
    vecs[7] = '{25'h2ABCD, 8'h38, 4'b0100, 25'hABCD};
    vecs[8] = '{25'h30000, 8'h49, 4'b1000, 25'h0};
    vecs[9] = '{25'h3FFFF, 8'h5A, 4'b1000, 25'hFFFF};

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.rgn_rdy        = 4'b1111;

    // ---- Reset values
    repeat (2) @(negedge i_clk);
    chk("rst core_rstn", 32'(core_rstn), 32'd0);
    chk("rst ioctl_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst rgn_wr", 32'(bus.rgn_wr), 32'd0);
    chk("rst game/dsw", {8'd0, game, dsw1, dsw2}, 32'd0);
    chk("rst loaded/ovf", {rom_loaded, rom_overflow}, 32'd0);
    RESETn = 1'b1;
    cyc();

    // ---- Routing through all regions with every region ready
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      put_byte(8'd0, vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d rgn_wr", i), 32'(bus.rgn_wr), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d rgn_addr", i), 32'(bus.rgn_addr), 32'(vecs[i].exp_off));
      chk($sformatf("v%0d rgn_data", i), 32'(bus.rgn_data), 32'(vecs[i].data));
      chk($sformatf("v%0d ioctl_wait", i), 32'(bus.ioctl_wait), 32'd0);
      cyc();
      chk($sformatf("v%0d strobe one cycle", i), 32'(bus.rgn_wr), 32'd0);
    end

    // ---- Region 2 busy for 5 cycles; a stray strobe during the stall is ignored
    bus.rgn_rdy = 4'b1011;
    put_byte(8'd0, 25'h20000, 8'h77);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d wait", k), 32'(bus.ioctl_wait), 32'd1);
      chk($sformatf("stall%0d no wr", k), 32'(bus.rgn_wr), 32'd0);
      if (k == 4) bus.rgn_rdy = 4'b1111;
      if (k == 2) put_byte(8'd0, 25'h30001, 8'hEE);
      else        cyc();
    end
    chk("stall release wr", 32'(bus.rgn_wr), 32'b0100);
    chk("stall release off", 32'(bus.rgn_addr), 32'h0);
    chk("stall release data", 32'(bus.rgn_data), 32'h77);
    chk("stall release wait", 32'(bus.ioctl_wait), 32'd0);
    cyc();
    chk("stall no duplicate", 32'(bus.rgn_wr), 32'd0);
    put_byte(8'd0, 25'h20001, 8'h88);
    chk("stall continue wr", 32'(bus.rgn_wr), 32'b0100);
    chk("stall continue off", 32'(bus.rgn_addr), 32'h1);
    chk("stall continue data", 32'(bus.rgn_data), 32'h88);

    // ---- Byte past the image end is dropped and flags overflow
    put_byte(8'd0, 25'h40000, 8'h99);
    chk("ovf no wr", 32'(bus.rgn_wr), 32'd0);
    chk("ovf flag", 32'(rom_overflow), 32'd1);
    put_byte(8'd0, 25'h3FFFE, 8'h42);
    chk("ovf after wr", 32'(bus.rgn_wr), 32'b1000);
    chk("ovf after off", 32'(bus.rgn_addr), 32'hFFFE);
    chk("ovf sticky", 32'(rom_overflow), 32'd1);
    cyc();
    finish_load("load1");
    chk("ovf sticky in RUN", 32'(rom_overflow), 32'd1);

    // ---- Config bytes in RUN: no stall, core stays out of reset
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd254;
    cyc();
    put_byte(8'd254, 25'd0, 8'h5A);
    chk("dsw wait0", 32'(bus.ioctl_wait), 32'd0);
    put_byte(8'd254, 25'd1, 8'hC3);
    chk("dsw wait1", 32'(bus.ioctl_wait), 32'd0);
    put_byte(8'd254, 25'd2, 8'hFF);
    chk("dsw wait2", 32'(bus.ioctl_wait), 32'd0);
    chk("dsw1", 32'(dsw1), 32'h5A);
    chk("dsw2", 32'(dsw2), 32'hC3);
    bus.ioctl_index = 8'd1;
    put_byte(8'd1, 25'd0, 8'h02);
    put_byte(8'd1, 25'd1, 8'h99);
    chk("game", 32'(game), 32'h02);
    chk("cfg wait", 32'(bus.ioctl_wait), 32'd0);
    chk("cfg no rgn_wr", 32'(bus.rgn_wr), 32'd0);
    chk("cfg core_rstn", 32'(core_rstn), 32'd1);
    bus.ioctl_download = 1'b0;
    cyc();
    chk("cfg core_rstn after", 32'(core_rstn), 32'd1);

    // ---- Reload from RUN: reset to the core on the same edge as the start
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'd0;
    cyc();
    chk("reload core_rstn", 32'(core_rstn), 32'd0);
    chk("reload rom_loaded", 32'(rom_loaded), 32'd0);
    chk("reload ovf cleared", 32'(rom_overflow), 32'd0);

    // ---- Async reset while stalled
    bus.rgn_rdy = 4'b1101;
    put_byte(8'd0, 25'h10000, 8'h5E);
    chk("hold before rst wait", 32'(bus.ioctl_wait), 32'd1);
    #2;
    RESETn = 1'b0;
    #1;
    chk("async rst wait", 32'(bus.ioctl_wait), 32'd0);
    chk("async rst core_rstn", 32'(core_rstn), 32'd0);
    chk("async rst dsw1", 32'(dsw1), 32'd0);
    bus.rgn_rdy = 4'b1111;
    @(negedge i_clk);
    RESETn = 1'b1;
    cyc();
    chk("post rst no stale wr", 32'(bus.rgn_wr), 32'd0);
    cyc();
    chk("post rst still no wr", 32'(bus.rgn_wr), 32'd0);
    put_byte(8'd0, 25'h0, 8'h11);
    chk("post rst wr", 32'(bus.rgn_wr), 32'b0001);
    chk("post rst off", 32'(bus.rgn_addr), 32'h0);
    chk("post rst data", 32'(bus.rgn_data), 32'h11);
    cyc();
    finish_load("load2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
